core_axi_rd_arbiter: RTL and testbench

//  Merges AR/R traffic from N_CLIENT cache refill engines (i-cache, d-cache) onto the core's single AXI master read channel.

---
 rtl/core_axi_pkg.sv | 23 ++
 rtl/core_rr_arbiter.sv | 45 ++++
 rtl/core_axi_rd_arbiter.sv | 160 ++++++++++++++++
 tb/tb_core_axi_rd_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_axi_pkg.sv
// Shared AXI read-path types and constant attribute fields for the core's bus-side blocks.
package core_axi_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_LEN_W  = 4;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [2:0]            size;
    } ar_req_t;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORM  = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'h0;
    localparam logic [2:0] AXI_PROT_DEF   = 3'h0;

endpackage

// File: rtl/core_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer; pointer moves past the winner on advance.
module core_rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[(32'(ptr_q) + k) % N]) begin
                found = 1'b1;
                win   = PW'((32'(ptr_q) + k) % N);
            end
        end
        if (found) begin
            grant[win] = 1'b1;
        end
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (32'(win) + 1 == N) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/core_axi_rd_arbiter.sv
// Merges per-client AR/R traffic onto one AXI read channel; client index is the AXI ID.
module core_axi_rd_arbiter
    import core_axi_pkg::*;
#(
    parameter int unsigned N_CLIENT = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LEN_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CLIENT-1:0]          c_ar_valid,
    output logic [N_CLIENT-1:0]          c_ar_ready,
    input  logic [N_CLIENT*ADDR_W-1:0]   c_ar_addr,
    input  logic [N_CLIENT*LEN_W-1:0]    c_ar_len,
    input  logic [N_CLIENT*3-1:0]        c_ar_size,
    output logic [N_CLIENT-1:0]          c_r_valid,
    input  logic [N_CLIENT-1:0]          c_r_ready,
    output logic [DATA_W-1:0]            c_r_data,
    output logic [1:0]                   c_r_resp,
    output logic                         c_r_last,
    output logic                         m_ar_valid,
    input  logic                         m_ar_ready,
    output logic [3:0]                   m_ar_id,
    output logic [ADDR_W-1:0]            m_ar_addr,
    output logic [LEN_W-1:0]             m_ar_len,
    output logic [2:0]                   m_ar_size,
    output logic [1:0]                   m_ar_burst,
    output logic [1:0]                   m_ar_lock,
    output logic [3:0]                   m_ar_cache,
    output logic [2:0]                   m_ar_prot,
    input  logic                         m_r_valid,
    output logic                         m_r_ready,
    input  logic [3:0]                   m_r_id,
    input  logic [DATA_W-1:0]            m_r_data,
    input  logic [1:0]                   m_r_resp,
    input  logic                         m_r_last,
    output logic                         err_o
);

    ar_state_e                       state_q, state_d;
    ar_req_t                         ar_q, ar_d;
    logic [3:0]                      id_q, id_d;
    logic [N_CLIENT-1:0]             busy_q, busy_d;
    logic [N_CLIENT-1:0][LEN_W-1:0]  cnt_q, cnt_d;
    logic [N_CLIENT-1:0][LEN_W-1:0]  len_q, len_d;
    logic                            err_q, err_d;

    logic [N_CLIENT-1:0] eligible, grant, sel_hit;
    logic                can_capture, capture;
    logic                sel_busy, sel_ready, r_hs;
    logic [LEN_W-1:0]    sel_cnt, sel_len;

    core_rr_arbiter #(.N(N_CLIENT)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eligible),
        .adv   (can_capture),
        .grant (grant)
    );

    always_comb begin
        eligible    = c_ar_valid & ~busy_q;
        can_capture = (state_q == AR_IDLE) || m_ar_ready;
        capture     = can_capture && (|eligible);

        sel_hit   = '0;
        sel_cnt   = '0;
        sel_len   = '0;
        for (int unsigned i = 0; i < N_CLIENT; i++) begin
            if (32'(m_r_id) == i) begin
                sel_hit[i] = 1'b1;
                sel_cnt    = cnt_q[i];
                sel_len    = len_q[i];
            end
        end
        sel_busy  = |(sel_hit & busy_q);
        sel_ready = |(sel_hit & c_r_ready);
        // Beats for unknown or idle IDs are swallowed so the bus never stalls on them.
        m_r_ready = sel_busy ? sel_ready : 1'b1;
        r_hs      = m_r_valid && m_r_ready;

        err_d = err_q;
        if (m_r_valid && !sel_busy) begin
            err_d = 1'b1;
        end else if (r_hs && (m_r_last != (sel_cnt == sel_len))) begin
            err_d = 1'b1;
        end

        state_d = state_q;
        ar_d    = ar_q;
        id_d    = id_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        for (int unsigned i = 0; i < N_CLIENT; i++) begin
            if (r_hs && sel_hit[i] && busy_q[i]) begin
                cnt_d[i] = cnt_q[i] + LEN_W'(1);
                if (m_r_last) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (capture && grant[i]) begin
                ar_d.addr = AXI_ADDR_W'(c_ar_addr[i*ADDR_W +: ADDR_W]);
                ar_d.len  = AXI_LEN_W'(c_ar_len[i*LEN_W +: LEN_W]);
                ar_d.size = c_ar_size[i*3 +: 3];
                id_d      = 4'(i);
                busy_d[i] = 1'b1;
                cnt_d[i]  = '0;
                len_d[i]  = c_ar_len[i*LEN_W +: LEN_W];
            end
        end

        if (capture) begin
            state_d = AR_HOLD;
        end else if (can_capture) begin
            state_d = AR_IDLE;
        end

        c_ar_ready = (capture && rst_n) ? grant : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AR_IDLE;
            ar_q    <= '0;
            id_q    <= '0;
            busy_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign m_ar_valid = (state_q == AR_HOLD);
    assign m_ar_id    = id_q;
    assign m_ar_addr  = ADDR_W'(ar_q.addr);
    assign m_ar_len   = LEN_W'(ar_q.len);
    assign m_ar_size  = ar_q.size;
    assign m_ar_burst = AXI_BURST_INCR;
    assign m_ar_lock  = AXI_LOCK_NORM;
    assign m_ar_cache = AXI_CACHE_DEF;
    assign m_ar_prot  = AXI_PROT_DEF;

    assign c_r_valid  = {N_CLIENT{m_r_valid}} & sel_hit & busy_q;
    assign c_r_data   = m_r_data;
    assign c_r_resp   = m_r_resp;
    assign c_r_last   = m_r_last;
    assign err_o      = err_q;

endmodule

// File: tb/tb_core_axi_rd_arbiter.sv
// Directed and random checks of the AXI read arbiter against a transaction-level model.
module tb_core_axi_rd_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    c_ar_valid, c_ar_ready, c_r_valid, c_r_ready;
    logic [N*AW-1:0] c_ar_addr;
    logic [N*LW-1:0] c_ar_len;
    logic [N*3-1:0]  c_ar_size;
    logic [DW-1:0]   c_r_data, m_r_data;
    logic [1:0]      c_r_resp, m_r_resp;
    logic            c_r_last, m_r_last;
    logic            m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, err_o;
    logic [3:0]      m_ar_id, m_r_id;
    logic [AW-1:0]   m_ar_addr;
    logic [LW-1:0]   m_ar_len;
    logic [2:0]      m_ar_size, m_ar_prot;
    logic [1:0]      m_ar_burst, m_ar_lock;
    logic [3:0]      m_ar_cache;

    core_axi_rd_arbiter #(.N_CLIENT(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_ar_valid(c_ar_valid), .c_ar_ready(c_ar_ready), .c_ar_addr(c_ar_addr),
        .c_ar_len(c_ar_len), .c_ar_size(c_ar_size),
        .c_r_valid(c_r_valid), .c_r_ready(c_r_ready), .c_r_data(c_r_data),
        .c_r_resp(c_r_resp), .c_r_last(c_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock), .m_ar_cache(m_ar_cache),
        .m_ar_prot(m_ar_prot),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding bursts per client, pending AR beat, and the bus-side beats still owed.
    bit          mbusy[N];
    int          mlen[N];
    int          mcnt[N];
    int          bus_left[N];
    bit          merr, mhold, r_hs;
    int          mptr;
    logic [31:0] maddr;
    logic [3:0]  mlen_o, mid;
    logic [2:0]  msize;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mbusy[i] = 0; mlen[i] = 0; mcnt[i] = 0; bus_left[i] = 0;
        end
        merr = 0; mhold = 0; mptr = 0; r_hs = 0;
        maddr = '0; mlen_o = '0; mid = '0; msize = '0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input int l, input int s);
        c_ar_valid[i]          = 1'b1;
        c_ar_addr[i*AW +: AW]  = a;
        c_ar_len[i*LW +: LW]   = 4'(l);
        c_ar_size[i*3 +: 3]    = 3'(s);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int         w;
        int         ri;
        bit         can, id_ok;
        logic [N-1:0] ea, ev;
        logic       emr;
        #1;
        w   = -1;
        can = !mhold || m_ar_ready;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mptr + k) % N;
                if (w < 0 && c_ar_valid[idx] && !mbusy[idx]) w = idx;
            end
        end
        ea = '0;
        if (w >= 0) ea[w] = 1'b1;
        id_ok = 0;
        ri    = int'(m_r_id);
        if (ri < N) id_ok = mbusy[ri];
        ev = '0;
        if (m_r_valid && id_ok) ev[ri] = 1'b1;
        emr = id_ok ? c_r_ready[ri] : 1'b1;

        check("c_ar_ready", 64'(c_ar_ready), 64'(ea));
        check("c_r_valid", 64'(c_r_valid), 64'(ev));
        check("m_r_ready", 64'(m_r_ready), 64'(emr));
        check("m_ar_valid", 64'(m_ar_valid), 64'(mhold));
        check("err_o", 64'(err_o), 64'(merr));
        if (ev != '0) begin
            check("c_r_data", 64'(c_r_data), 64'(m_r_data));
            check("c_r_last", 64'(c_r_last), 64'(m_r_last));
        end
        if (mhold) begin
            check("m_ar_id", 64'(m_ar_id), 64'(mid));
            check("m_ar_addr", 64'(m_ar_addr), 64'(maddr));
            check("m_ar_len", 64'(m_ar_len), 64'(mlen_o));
            check("m_ar_size", 64'(m_ar_size), 64'(msize));
        end

        @(posedge clk);
        r_hs = m_r_valid && emr;
        if (m_r_valid && !id_ok) begin
            merr = 1;
        end else if (r_hs) begin
            if (m_r_last != (mcnt[ri] == mlen[ri])) merr = 1;
            mcnt[ri] = (mcnt[ri] + 1) % 16;
            if (m_r_last) mbusy[ri] = 0;
            if (bus_left[ri] > 0) bus_left[ri]--;
        end
        if (mhold && m_ar_ready) bus_left[mid] = int'(mlen_o) + 1;
        if (w >= 0) begin
            mbusy[w] = 1;
            mcnt[w]  = 0;
            mlen[w]  = int'(c_ar_len[w*LW +: LW]);
            maddr    = c_ar_addr[w*AW +: AW];
            mlen_o   = c_ar_len[w*LW +: LW];
            msize    = c_ar_size[w*3 +: 3];
            mid      = 4'(w);
            mhold    = 1;
            mptr     = (w + 1) % N;
        end else if (can) begin
            mhold = 0;
        end
        @(negedge clk);
        if (w >= 0) c_ar_valid[w] = 1'b0;
    endtask

    task automatic beat(input int id, input bit last, input logic [N-1:0] rdy);
        m_r_valid = 1'b1;
        m_r_id    = 4'(id);
        m_r_last  = last;
        m_r_data  = $urandom;
        m_r_resp  = 2'($urandom_range(0, 3));
        c_r_ready = rdy;
        cycle();
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_m_ar_valid", 64'(m_ar_valid), 64'(0));
        check("rst_c_ar_ready", 64'(c_ar_ready), 64'(0));
        check("rst_c_r_valid", 64'(c_r_valid), 64'(0));
        check("rst_err_o", 64'(err_o), 64'(0));
        model_reset();
        c_ar_valid = '0;
        m_r_valid  = 1'b0;
        m_r_last   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ids[N];
        int n;
        int pick;
        rst_n = 1'b0;
        c_ar_valid = '0; c_ar_addr = '0; c_ar_len = '0; c_ar_size = '0;
        c_r_ready = '0; m_ar_ready = 1'b0;
        m_r_valid = 1'b0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0;
        model_reset();
        c_ar_valid = 2'b11;
        @(negedge clk);
        #1;
        check("rst_c_ar_ready_held", 64'(c_ar_ready), 64'(0));
        check("rst_m_ar_valid_held", 64'(m_ar_valid), 64'(0));
        check("rst_err_held", 64'(err_o), 64'(0));
        check("ar_burst", 64'(m_ar_burst), 64'(2'b01));
        check("ar_attr", 64'({m_ar_lock, m_ar_cache, m_ar_prot}), 64'(0));
        c_ar_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single 4-beat burst from client 0
        set_req(0, 32'h1C00_0000, 3, 2);
        m_ar_ready = 1'b1;
        cycle();
        cycle();
        for (int b = 0; b < 4; b++) beat(0, b == 3, 2'b11);
        beat(0, 1'b1, 2'b11);
        do_reset();

        // Contention with pointer at 0: back-to-back grants 0 then 1
        m_ar_ready = 1'b1;
        set_req(0, $urandom, 0, 2);
        set_req(1, $urandom, 0, 2);
        cycle();
        cycle();
        cycle();
        cycle();
        beat(0, 1'b1, 2'b11);
        beat(1, 1'b1, 2'b11);

        // AR backpressure for 5 cycles with a second request waiting
        m_ar_ready = 1'b0;
        set_req(1, $urandom, 1, 1);
        cycle();
        set_req(0, $urandom, 1, 2);
        repeat (5) cycle();
        m_ar_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        // Interleaved R with a stalled beat in the middle
        beat(1, 1'b0, 2'b11);
        beat(0, 1'b0, 2'b10);
        beat(0, 1'b0, 2'b01);
        beat(1, 1'b1, 2'b10);
        beat(0, 1'b1, 2'b01);
        cycle();

        // Unknown ID is drained and flags a sticky error
        beat(3, 1'b1, 2'b00);
        cycle();
        cycle();

        // Reset mid-burst, then a fresh request
        set_req(0, $urandom, 3, 2);
        cycle();
        cycle();
        beat(0, 1'b0, 2'b11);
        m_r_valid = 1'b1;
        m_r_id    = 4'd0;
        do_reset();
        m_ar_ready = 1'b1;
        set_req(1, $urandom, 0, 2);
        cycle();
        cycle();
        beat(1, 1'b1, 2'b11);
        cycle();

        // Early last on beat 2 of a 4-beat burst
        set_req(0, $urandom, 3, 2);
        cycle();
        cycle();
        beat(0, 1'b0, 2'b11);
        beat(0, 1'b1, 2'b11);
        cycle();
        do_reset();

        // Random legal traffic
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!c_ar_valid[i] && ($urandom_range(0, 3) == 0))
                    set_req(i, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
            end
            m_ar_ready = 1'($urandom_range(0, 1));
            c_r_ready  = 2'($urandom_range(0, 3));
            if (!m_r_valid || r_hs) begin
                n = 0;
                for (int i = 0; i < N; i++) if (bus_left[i] > 0) begin ids[n] = i; n++; end
                if (n > 0 && $urandom_range(0, 2) != 0) begin
                    pick      = ids[$urandom_range(0, n - 1)];
                    m_r_valid = 1'b1;
                    m_r_id    = 4'(pick);
                    m_r_last  = (bus_left[pick] == 1);
                    m_r_data  = $urandom;
                    m_r_resp  = 2'($urandom_range(0, 3));
                end else begin
                    m_r_valid = 1'b0;
                    m_r_last  = 1'b0;
                end
            end
            cycle();
        end
        m_r_valid  = 1'b0;
        c_ar_valid = '0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
